psum_ofifo: RTL and testbench
=============================

PSUM_OFIFO -- requirements
Module: psum_ofifo

Interface
REQ-001 The block SHALL have parameter psum_bw, default 16, giving the width of one signed partial sum in bits.
REQ-002 The block SHALL have parameter col, default 8, giving the number of array columns (lanes).
REQ-003 The block SHALL have parameter depth, default 16, giving the entries per lane; it is a power of two, >= 2.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port wr, input, col bits: per-lane write strobe from the array's column outputs.
REQ-007 The block SHALL have port in, input, psum_bw*col bits: per-lane psum data; lane g occupies bits [psum_bw*(g+1)-1 : psum_bw*g].
REQ-008 The block SHALL have port rd, input, 1 bit: row pop request from the SFU/accumulation controller.
REQ-009 The block SHALL have port out, output, psum_bw*col bits: the row of lane heads, in the same lane packing as in, that feeds the SFU psum input.
REQ-010 The block SHALL have port o_valid, output, 1 bit: a complete row (every lane non-empty) is present on out.
REQ-011 The block SHALL have port o_full, output, 1 bit: at least one lane holds depth entries.
REQ-012 The block SHALL have port o_ready, output, 1 bit: the logical inverse of o_full.
REQ-013 The block SHALL have port o_overflow, output, 1 bit: a sticky flag set by any dropped write.

Function
REQ-014 Each lane SHALL be an independent circular FIFO with its own write pointer and entry count; the read pointer SHALL be shared by all lanes.
REQ-015 Pointers SHALL be log2(depth) bits and wrap from depth-1 to 0; counts SHALL be log2(depth)+1 bits and range 0..depth.
REQ-016 A write to lane g when wr[g]=1 and count[g]<depth SHALL store the in lane-g slice at wptr[g], then increment wptr[g] and count[g].
REQ-017 o_valid SHALL be combinational, equal to 1 exactly when every lane count is >= 1.
REQ-018 out SHALL be first-word-fall-through: it shows the entry at the shared read pointer for every lane while o_valid=1, and is all zeros while o_valid=0.
REQ-019 When rd=1 and o_valid=1, the block SHALL pop one entry from every lane on that edge: the read pointer increments and every count decrements.
REQ-020 When rd=1 and o_valid=0, the block SHALL ignore the request and leave all state unchanged.
REQ-021 When a lane is full and, in the same cycle, wr[g]=1 and a valid pop occurs, the write SHALL be accepted and count[g] SHALL stay at depth.
REQ-022 When a lane is full and wr[g]=1 with no valid pop, the write SHALL be dropped and o_overflow SHALL be set on that edge.
REQ-023 When a lane is empty and wr[g]=1 while rd=1, the write SHALL be stored; the pop SHALL not occur (o_valid=0 that cycle); the new data SHALL appear on out no earlier than the next cycle.
REQ-024 Writes to different lanes in the same cycle SHALL be independent; the lane counts may differ by up to depth.
REQ-025 o_full and o_ready SHALL be combinational from the current lane counts.
REQ-026 Once set, o_overflow SHALL remain 1 until reset.
REQ-027 The storage array SHALL not be reset; its content is unobservable until written, because out is masked by o_valid.

Reset
REQ-028 With reset=1 at a rising edge, the block SHALL clear all write pointers, the read pointer, all counts and o_overflow, giving o_valid=0, out=0, o_full=0, o_ready=1 after that edge.
REQ-029 Reset SHALL take priority over wr and rd in the same cycle; a reset mid-operation SHALL discard all buffered rows.
REQ-030 The first write SHALL be accepted on the first rising edge with reset=0.

Verification
REQ-031 Bench scenario, skewed fill: with col=8, write lane g with value 100+g starting at cycle g, one write per lane. o_valid SHALL stay 0 until lane 7 is written; it SHALL then be 1 with out lanes = 100..107. On rd=1, o_valid SHALL return to 0.
REQ-032 Bench scenario, fill then drain: write 16 rows of value k (k=0..15) to all lanes. o_full=1 and o_ready=0 SHALL result. Issue 16 pops. Rows SHALL emerge in order 0..15, then o_valid=0 and o_full=0.
REQ-033 Bench scenario, wrap-around: perform 40 write/pop pairs with value -n (signed) at depth 16. Every popped value SHALL match its write order and sign, with no overflow.
REQ-034 Bench scenario, full plus simultaneous: with lane 3 full, drive wr[3]=1 with rd=1 and o_valid=1. The write SHALL be accepted and o_overflow SHALL stay 0. Next, drive wr[3]=1 with rd=0. o_overflow SHALL become 1 and the lane-3 contents SHALL be unchanged.
REQ-035 Bench scenario, rd while empty: pulse rd with o_valid=0. State SHALL be unchanged, and a row written afterwards SHALL pop correctly.
REQ-036 Bench scenario, reset mid-operation: with 5 rows buffered and o_overflow=1, assert reset for one cycle. The next cycle SHALL show o_valid=0, out=0, o_overflow=0 and o_ready=1.

Source files
------------

// File: rtl/psum_ofifo.sv
// Output FIFO collecting per-column partial sums from the array and presenting
// complete rows to the SFU. Each lane fills independently; rows pop together.
module psum_ofifo #(
   parameter int unsigned psum_bw = 16,
   parameter int unsigned col     = 8,
   parameter int unsigned depth   = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [col-1:0]         wr,
   input  logic [psum_bw*col-1:0] in,
   input  logic                   rd,
   output logic [psum_bw*col-1:0] out,
   output logic                   o_valid,
   output logic                   o_full,
   output logic                   o_ready,
   output logic                   o_overflow
);

   localparam int unsigned AW = $clog2(depth);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(depth);

   logic [psum_bw-1:0] mem_q [col][depth];
   logic [AW-1:0]      wptr_q [col];
   logic [AW-1:0]      wptr_d [col];
   logic [CW-1:0]      cnt_q  [col];
   logic [CW-1:0]      cnt_d  [col];
   logic [AW-1:0]      rptr_q;
   logic [AW-1:0]      rptr_d;
   logic               ovf_q;
   logic               ovf_d;
   logic [col-1:0]     wr_ok_c;
   logic               pop_c;

   // Row-complete and any-lane-full status from current lane counts
   always_comb begin
      o_valid = 1'b1;
      o_full  = 1'b0;
      for (int unsigned g = 0; g < col; g++) begin
         if (cnt_q[g] == '0)     o_valid = 1'b0;
         if (cnt_q[g] == DEPTH_C) o_full = 1'b1;
      end
      o_ready = ~o_full;
      pop_c   = rd & o_valid;
   end

   // Per-lane write acceptance, pointer/count next state and overflow detection
   always_comb begin
      wr_ok_c = '0;
      rptr_d  = rptr_q + AW'(pop_c);
      ovf_d   = ovf_q;
      for (int unsigned g = 0; g < col; g++) begin
         // A full lane still accepts a write when the same edge frees a slot
         wr_ok_c[g] = wr[g] & ((cnt_q[g] != DEPTH_C) | pop_c);
         wptr_d[g]  = wptr_q[g] + AW'(wr_ok_c[g]);
         cnt_d[g]   = cnt_q[g] + CW'(wr_ok_c[g]) - CW'(pop_c);
         if (wr[g] && !wr_ok_c[g]) ovf_d = 1'b1;
      end
   end

   // First-word-fall-through row of lane heads, masked until the row is complete
   always_comb begin
      out = '0;
      for (int unsigned g = 0; g < col; g++) begin
         out[g*psum_bw +: psum_bw] = o_valid ? mem_q[g][rptr_q] : '0;
      end
   end

   // Pointer, count and sticky overflow registers
   always_ff @(posedge clk) begin
      if (reset) begin
         rptr_q <= '0;
         ovf_q  <= 1'b0;
         for (int unsigned g = 0; g < col; g++) begin
            wptr_q[g] <= '0;
            cnt_q[g]  <= '0;
         end
      end else begin
         rptr_q <= rptr_d;
         ovf_q  <= ovf_d;
         for (int unsigned g = 0; g < col; g++) begin
            wptr_q[g] <= wptr_d[g];
            cnt_q[g]  <= cnt_d[g];
         end
      end
   end

   // Storage array; content is hidden by the o_valid mask so it needs no reset
   always_ff @(posedge clk) begin
      for (int unsigned g = 0; g < col; g++) begin
         if (!reset && wr_ok_c[g]) begin
            mem_q[g][wptr_q[g]] <= in[g*psum_bw +: psum_bw];
         end
      end
   end

   assign o_overflow = ovf_q;

endmodule

// File: tb/tb_psum_ofifo.sv
// Randomized and directed bench for psum_ofifo against a queue-based lane model.
module tb_psum_ofifo;

   localparam int unsigned BW = 16;
   localparam int unsigned NC = 8;
   localparam int unsigned DP = 16;

   logic            clk;
   logic            reset;
   logic [NC-1:0]   wr;
   logic [BW*NC-1:0] in;
   logic            rd;
   logic [BW*NC-1:0] out;
   logic            o_valid;
   logic            o_full;
   logic            o_ready;
   logic            o_overflow;

   int tests;
   int failed;

   // Reference: one queue per lane plus a sticky overflow bit
   logic [BW-1:0] mq [NC][$];
   bit            movf;

   psum_ofifo #(.psum_bw(BW), .col(NC), .depth(DP)) dut (
      .clk(clk), .reset(reset), .wr(wr), .in(in), .rd(rd), .out(out),
      .o_valid(o_valid), .o_full(o_full), .o_ready(o_ready), .o_overflow(o_overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic m_valid();
      for (int l = 0; l < NC; l++) if (mq[l].size() == 0) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic m_full();
      for (int l = 0; l < NC; l++) if (mq[l].size() == DP) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [BW*NC-1:0] m_out();
      logic [BW*NC-1:0] r;
      r = '0;
      if (m_valid()) for (int l = 0; l < NC; l++) r[l*BW +: BW] = mq[l][0];
      return r;
   endfunction

   function automatic logic [BW*NC-1:0] row(input logic [BW-1:0] v);
      return {NC{v}};
   endfunction

   task automatic model_step(input logic rst, input logic [NC-1:0] w,
                             input logic [BW*NC-1:0] d, input logic r);
      logic p;
      if (rst) begin
         for (int l = 0; l < NC; l++) mq[l].delete();
         movf = 1'b0;
         return;
      end
      p = r && m_valid();
      for (int l = 0; l < NC; l++) begin
         if (w[l]) begin
            if (mq[l].size() < DP || p) mq[l].push_back(d[l*BW +: BW]);
            else movf = 1'b1;
         end
      end
      if (p) for (int l = 0; l < NC; l++) void'(mq[l].pop_front());
   endtask

   // Drive one cycle, advance the model on the edge, settle before checks
   task automatic step(input logic rst, input logic [NC-1:0] w,
                       input logic [BW*NC-1:0] d, input logic r);
      reset = rst; wr = w; in = d; rd = r;
      @(posedge clk);
      model_step(rst, w, d, r);
      #1;
      reset = 1'b0; wr = '0; rd = 1'b0;
   endtask

   task automatic test_reset();
      step(1'b1, '1, row(16'hFFFF), 1'b1);
      step(1'b1, '0, '0, 1'b0);
      tests++; if (o_valid !== 1'b0) begin failed++; $display("FAIL reset_valid got %b want 0", o_valid); end
      tests++; if (out !== '0) begin failed++; $display("FAIL reset_out got %h want 0", out); end
      tests++; if (o_full !== 1'b0 || o_ready !== 1'b1) begin failed++;
         $display("FAIL reset_full_ready got %b/%b want 0/1", o_full, o_ready); end
      tests++; if (o_overflow !== 1'b0) begin failed++; $display("FAIL reset_ovf got %b want 0", o_overflow); end
   endtask

   task automatic test_skewed_fill();
      logic [BW*NC-1:0] d;
      logic [BW*NC-1:0] exp;
      step(1'b1, '0, '0, 1'b0);
      for (int g = 0; g < NC; g++) begin
         d = '0; d[g*BW +: BW] = BW'(100 + g);
         step(1'b0, NC'(1) << g, d, 1'b0);
         tests++; if (o_valid !== (g == NC-1)) begin failed++;
            $display("FAIL skew_valid lane %0d got %b want %b", g, o_valid, (g == NC-1)); end
      end
      for (int g = 0; g < NC; g++) exp[g*BW +: BW] = BW'(100 + g);
      tests++; if (out !== exp) begin failed++; $display("FAIL skew_out got %h want %h", out, exp); end
      step(1'b0, '0, '0, 1'b1);
      tests++; if (o_valid !== 1'b0 || out !== '0) begin failed++;
         $display("FAIL skew_pop got valid %b out %h want 0/0", o_valid, out); end
   endtask

   task automatic test_fill_drain();
      step(1'b1, '0, '0, 1'b0);
      for (int k = 0; k < DP; k++) step(1'b0, '1, row(BW'(k)), 1'b0);
      tests++; if (o_full !== 1'b1 || o_ready !== 1'b0) begin failed++;
         $display("FAIL fill_full got full %b ready %b want 1/0", o_full, o_ready); end
      for (int k = 0; k < DP; k++) begin
         tests++; if (o_valid !== 1'b1 || out !== row(BW'(k))) begin failed++;
            $display("FAIL drain_row %0d got valid %b out %h want 1 %h", k, o_valid, out, row(BW'(k))); end
         step(1'b0, '0, '0, 1'b1);
      end
      tests++; if (o_valid !== 1'b0 || o_full !== 1'b0) begin failed++;
         $display("FAIL drain_end got valid %b full %b want 0/0", o_valid, o_full); end
   endtask

   task automatic test_wrap();
      logic [BW-1:0] v;
      step(1'b1, '0, '0, 1'b0);
      for (int n = 1; n <= 40; n++) begin
         v = BW'(-n);
         step(1'b0, '1, row(v), 1'b0);
         tests++; if (out !== row(v) || $signed(out[BW-1:0]) != -n) begin failed++;
            $display("FAIL wrap_row %0d got %h want %h", n, out, row(v)); end
         step(1'b0, '0, '0, 1'b1);
      end
      tests++; if (o_overflow !== 1'b0 || o_valid !== 1'b0) begin failed++;
         $display("FAIL wrap_end got ovf %b valid %b want 0/0", o_overflow, o_valid); end
   endtask

   task automatic test_full_simul();
      logic [BW*NC-1:0] d;
      logic [BW-1:0]    e;
      step(1'b1, '0, '0, 1'b0);
      for (int i = 0; i < DP; i++) begin
         d = '0; d[3*BW +: BW] = BW'(200 + i);
         step(1'b0, 8'h08, d, 1'b0);
      end
      step(1'b0, 8'hF7, row(16'd1), 1'b0);
      tests++; if (o_valid !== 1'b1 || o_full !== 1'b1) begin failed++;
         $display("FAIL fs_setup got valid %b full %b want 1/1", o_valid, o_full); end
      d = '0; d[3*BW +: BW] = 16'h0BAD;
      step(1'b0, 8'h08, d, 1'b1);
      tests++; if (o_overflow !== 1'b0 || o_full !== 1'b1) begin failed++;
         $display("FAIL fs_simul got ovf %b full %b want 0/1", o_overflow, o_full); end
      d = '0; d[3*BW +: BW] = 16'hDEAD;
      step(1'b0, 8'h08, d, 1'b0);
      tests++; if (o_overflow !== 1'b1) begin failed++; $display("FAIL fs_drop got ovf %b want 1", o_overflow); end
      for (int i = 0; i < DP; i++) step(1'b0, 8'hF7, row(16'd2), 1'b0);
      for (int i = 0; i < DP; i++) begin
         e = (i < DP-1) ? BW'(201 + i) : 16'h0BAD;
         tests++; if (o_valid !== 1'b1 || out[3*BW +: BW] !== e || out !== m_out()) begin failed++;
            $display("FAIL fs_lane3 %0d got %h want %h (row %h want %h)", i, out[3*BW +: BW], e, out, m_out()); end
         step(1'b0, '0, '0, 1'b1);
      end
   endtask

   task automatic test_rd_empty();
      step(1'b1, '0, '0, 1'b0);
      step(1'b0, '0, '0, 1'b1);
      tests++; if (o_valid !== 1'b0 || out !== '0 || o_full !== 1'b0 || o_overflow !== 1'b0) begin failed++;
         $display("FAIL rde_state got valid %b out %h full %b ovf %b want 0", o_valid, out, o_full, o_overflow); end
      step(1'b0, '1, row(16'h1234), 1'b0);
      tests++; if (o_valid !== 1'b1 || out !== row(16'h1234)) begin failed++;
         $display("FAIL rde_row got valid %b out %h want 1 %h", o_valid, out, row(16'h1234)); end
      step(1'b0, '0, '0, 1'b1);
      tests++; if (o_valid !== 1'b0) begin failed++; $display("FAIL rde_pop got valid %b want 0", o_valid); end
      // Write into empty lanes while rd is high: data kept, no pop
      step(1'b0, '1, row(16'd55), 1'b1);
      tests++; if (o_valid !== 1'b1 || out !== row(16'd55)) begin failed++;
         $display("FAIL rde_wr_rd got valid %b out %h want 1 %h", o_valid, out, row(16'd55)); end
   endtask

   task automatic test_reset_mid();
      step(1'b1, '0, '0, 1'b0);
      for (int k = 0; k < 5; k++) step(1'b0, '1, row(BW'(k + 30)), 1'b0);
      for (int k = 0; k < 12; k++) step(1'b0, 8'h01, row(16'h7777), 1'b0);
      tests++; if (o_overflow !== 1'b1 || o_valid !== 1'b1) begin failed++;
         $display("FAIL rm_setup got ovf %b valid %b want 1/1", o_overflow, o_valid); end
      step(1'b1, '1, row(16'h4444), 1'b1);
      tests++; if (o_valid !== 1'b0 || out !== '0 || o_overflow !== 1'b0 || o_ready !== 1'b1) begin failed++;
         $display("FAIL rm_after got valid %b out %h ovf %b ready %b want 0/0/0/1",
                  o_valid, out, o_overflow, o_ready); end
      step(1'b0, '1, row(16'd9), 1'b0);
      tests++; if (o_valid !== 1'b1 || out !== row(16'd9)) begin failed++;
         $display("FAIL rm_first_wr got valid %b out %h want 1 %h", o_valid, out, row(16'd9)); end
   endtask

   task automatic test_random();
      logic [BW*NC-1:0] d;
      logic [NC-1:0]    w;
      logic             r;
      logic             rs;
      step(1'b1, '0, '0, 1'b0);
      for (int c = 0; c < 600; c++) begin
         for (int l = 0; l < NC; l++) d[l*BW +: BW] = BW'($urandom);
         // Phases bias toward filling or draining so full and empty both occur
         if ((c / 100) % 2 == 0) begin
            w = NC'($urandom) | NC'($urandom);
            r = ($urandom_range(0, 3) == 0);
         end else begin
            w = NC'($urandom) & NC'($urandom);
            r = ($urandom_range(0, 3) != 0);
         end
         rs = ($urandom_range(0, 199) == 0);
         step(rs, w, d, r);
         tests++; if (o_valid !== m_valid() || out !== m_out()) begin failed++;
            $display("FAIL rnd_row cyc %0d got valid %b out %h want %b %h", c, o_valid, out, m_valid(), m_out()); end
         tests++; if (o_full !== m_full() || o_ready !== !m_full() || o_overflow !== movf) begin failed++;
            $display("FAIL rnd_flags cyc %0d got full %b ready %b ovf %b want %b %b %b",
                     c, o_full, o_ready, o_overflow, m_full(), !m_full(), movf); end
      end
   endtask

   initial begin
      tests  = 0;
      failed = 0;
      movf   = 1'b0;
      reset  = 1'b1;
      wr     = '0;
      in     = '0;
      rd     = 1'b0;
      test_reset();
      test_skewed_fill();
      test_fill_drain();
      test_wrap();
      test_full_simul();
      test_rd_empty();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
